// File: rtl/rst_seq_pkg.sv
// -----------------------------------------------------------------------------
// rst_seq_pkg
//   Shared types and helpers for the reset sequencer.
//   - rst_seq_state_t : sequencer FSM states
//   - cnt_w()         : bit width needed for a counter that takes n_vals values
//                       (0 .. n_vals-1), never less than 1 bit
// -----------------------------------------------------------------------------
package rst_seq_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        RELEASE   = 2'd1,
        RUN       = 2'd2,
        HOLD      = 2'd3
    } rst_seq_state_t;

    function automatic int cnt_w(input int n_vals);
        return (n_vals <= 2) ? 1 : $clog2(n_vals);
    endfunction

endpackage

// File: rtl/sync_ff.sv
// -----------------------------------------------------------------------------
// sync_ff
//   Multi-flop synchroniser for a single-bit asynchronous input.
//   Ports:
//     clk   in  1  destination clock
//     rst_n in  1  asynchronous active-low reset, loads RST_VAL into every flop
//     d     in  1  asynchronous input
//     q     out 1  synchronised output (STAGES cycles of latency)
// -----------------------------------------------------------------------------
module sync_ff #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= {STAGES{RST_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/rst_seq_ctl.sv
// -----------------------------------------------------------------------------
// rst_seq_ctl
//   Reset sequencer for the system clock domain. Waits for a filtered PLL lock,
//   then releases N_CH active-low reset channels in index order, each after its
//   own delay. Lock loss or a software request pulls every channel low for at
//   least MIN_ASSERT cycles and restarts the whole sequence.
//   Ports:
//     clk_i         in  1     system clock
//     rst_n_i       in  1     asynchronous active-low reset
//     pll_locked_i  in  1     PLL lock, asynchronous to clk_i
//     sw_rst_req_i  in  1     synchronous single-cycle software reset request
//     rst_n_o       out N_CH  channel resets, active-low, bit k = channel k
//     rst_done_o    out 1     high while every channel is released (RUN)
//     lock_lost_o   out 1     sticky lock-loss flag, cleared only by rst_n_i
// -----------------------------------------------------------------------------
module rst_seq_ctl
    import rst_seq_pkg::*;
#(
    parameter int                      N_CH        = 4,
    parameter int                      SYNC_STAGES = 2,
    parameter int                      LOCK_FILT   = 16,
    parameter int                      DELAY_W     = 8,
    parameter logic [N_CH*DELAY_W-1:0] CH_DELAY    = {N_CH{DELAY_W'(4)}},
    parameter int                      MIN_ASSERT  = 8
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            pll_locked_i,
    input  logic            sw_rst_req_i,
    output logic [N_CH-1:0] rst_n_o,
    output logic            rst_done_o,
    output logic            lock_lost_o
);

    localparam int FILT_W = cnt_w(LOCK_FILT);
    localparam int HOLD_W = cnt_w(MIN_ASSERT);
    localparam int IDX_W  = cnt_w(N_CH);

    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILT - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MIN_ASSERT - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_CH - 1);

    generate
        if (N_CH < 1) begin : g_chk_nch
            $error("rst_seq_ctl: N_CH must be >= 1");
        end
        if (SYNC_STAGES < 2) begin : g_chk_sync
            $error("rst_seq_ctl: SYNC_STAGES must be >= 2");
        end
        if (LOCK_FILT < 1) begin : g_chk_filt
            $error("rst_seq_ctl: LOCK_FILT must be >= 1");
        end
        if (MIN_ASSERT < 1) begin : g_chk_hold
            $error("rst_seq_ctl: MIN_ASSERT must be >= 1");
        end
    endgenerate

    rst_seq_state_t     state;
    logic [FILT_W-1:0]  filt_cnt;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [DELAY_W-1:0] dly_cnt;
    logic [IDX_W-1:0]   idx;
    logic               lock_s;
    logic               hold_req;
    logic [DELAY_W-1:0] cur_dly;

    sync_ff #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b0)
    ) u_lock_sync (
        .clk   (clk_i),
        .rst_n (rst_n_i),
        .d     (pll_locked_i),
        .q     (lock_s)
    );

    assign hold_req = ~lock_s | sw_rst_req_i;

    // Delay field of the channel currently being timed.
    always_comb begin
        cur_dly = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (idx == IDX_W'(k)) begin
                cur_dly = CH_DELAY[k*DELAY_W +: DELAY_W];
            end
        end
    end

    // Every counter only increments while below its terminal value, so none
    // of them can wrap.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= WAIT_LOCK;
            filt_cnt    <= '0;
            hold_cnt    <= '0;
            dly_cnt     <= '0;
            idx         <= '0;
            rst_n_o     <= '0;
            rst_done_o  <= 1'b0;
            lock_lost_o <= 1'b0;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    if (lock_s) begin
                        if (filt_cnt == FILT_LAST) begin
                            state    <= RELEASE;
                            filt_cnt <= '0;
                            idx      <= '0;
                            dly_cnt  <= '0;
                        end else begin
                            filt_cnt <= filt_cnt + 1'b1;
                        end
                    end else begin
                        filt_cnt <= '0;
                    end
                end

                RELEASE: begin
                    if (!lock_s) begin
                        lock_lost_o <= 1'b1;
                    end
                    // Going to HOLD wins over a release due this same cycle.
                    if (hold_req) begin
                        state      <= HOLD;
                        rst_n_o    <= '0;
                        rst_done_o <= 1'b0;
                        hold_cnt   <= '0;
                        dly_cnt    <= '0;
                        idx        <= '0;
                    end else if (dly_cnt == cur_dly) begin
                        for (int k = 0; k < N_CH; k++) begin
                            if (idx == IDX_W'(k)) begin
                                rst_n_o[k] <= 1'b1;
                            end
                        end
                        dly_cnt <= '0;
                        if (idx == IDX_LAST) begin
                            state      <= RUN;
                            rst_done_o <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        dly_cnt <= dly_cnt + 1'b1;
                    end
                end

                RUN: begin
                    if (!lock_s) begin
                        lock_lost_o <= 1'b1;
                    end
                    if (hold_req) begin
                        state      <= HOLD;
                        rst_n_o    <= '0;
                        rst_done_o <= 1'b0;
                        hold_cnt   <= '0;
                        dly_cnt    <= '0;
                        idx        <= '0;
                    end
                end

                HOLD: begin
                    // Lock and software requests are ignored here; the filter
                    // in WAIT_LOCK re-qualifies the lock afterwards.
                    if (hold_cnt == HOLD_LAST) begin
                        state    <= WAIT_LOCK;
                        hold_cnt <= '0;
                        filt_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= WAIT_LOCK;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rst_seq_ctl.sv
// -----------------------------------------------------------------------------
// tb_rst_seq_ctl
//   Three sequencer configurations driven by shared stimulus (default
//   parameters, a minimal single-channel build, and an eight-channel build with
//   mixed delays). Each one is compared every cycle against a schedule model:
//   once the lock has been seen high for LOCK_FILT consecutive cycles, channel k
//   must be released exactly sum_{j<=k}(delay_j+1) cycles later, unless a lock
//   loss or software request aborts the sequence into a MIN_ASSERT-cycle hold.
// -----------------------------------------------------------------------------
module tb_rst_seq_ctl;

    localparam int P_WAIT = 0;
    localparam int P_SEQ  = 1;
    localparam int P_HOLD = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic pll   = 1'b0;
    logic sw    = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    function automatic int c_nch(input int g);
        case (g)
            0:       return 4;
            1:       return 1;
            default: return 8;
        endcase
    endfunction

    function automatic int c_ss(input int g);
        return (g == 2) ? 3 : 2;
    endfunction

    function automatic int c_lf(input int g);
        case (g)
            0:       return 16;
            1:       return 1;
            default: return 5;
        endcase
    endfunction

    function automatic int c_ma(input int g);
        case (g)
            0:       return 8;
            1:       return 1;
            default: return 3;
        endcase
    endfunction

    function automatic logic [63:0] c_dly(input int g);
        case (g)
            0:       return 64'h0000_0000_0404_0404;
            1:       return 64'h0;
            default: return 64'h0600_0205_0103_0007;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int          NC   = c_nch(g);
        localparam int          SS   = c_ss(g);
        localparam int          LF   = c_lf(g);
        localparam int          MA   = c_ma(g);
        localparam logic [63:0] DALL = c_dly(g);

        logic [NC-1:0] rv;
        logic          done;
        logic          lost;
        logic [NC-1:0] er;
        logic          ed;
        logic          el;

        rst_seq_ctl #(
            .N_CH        (NC),
            .SYNC_STAGES (SS),
            .LOCK_FILT   (LF),
            .DELAY_W     (8),
            .CH_DELAY    (DALL[NC*8-1:0]),
            .MIN_ASSERT  (MA)
        ) dut (
            .clk_i        (clk),
            .rst_n_i      (rst_n),
            .pll_locked_i (pll),
            .sw_rst_req_i (sw),
            .rst_n_o      (rv),
            .rst_done_o   (done),
            .lock_lost_o  (lost)
        );

        initial begin : model
            int   phase;
            int   run;
            int   t;
            int   acc;
            int   cum [NC];
            logic ls;
            logic sh [SS];

            acc = 0;
            for (int k = 0; k < NC; k++) begin
                acc    = acc + int'(DALL[k*8 +: 8]) + 1;
                cum[k] = acc;
            end
            phase = P_WAIT;
            run   = 0;
            t     = 0;
            er    = '0;
            ed    = 1'b0;
            el    = 1'b0;
            foreach (sh[i]) sh[i] = 1'b0;

            forever begin
                @(posedge clk or negedge rst_n);
                if (!rst_n) begin
                    phase = P_WAIT;
                    run   = 0;
                    t     = 0;
                    er    = '0;
                    ed    = 1'b0;
                    el    = 1'b0;
                    foreach (sh[i]) sh[i] = 1'b0;
                end else begin
                    ls = sh[SS-1];
                    for (int i = SS - 1; i > 0; i--) sh[i] = sh[i-1];
                    sh[0] = pll;
                    case (phase)
                        P_WAIT: begin
                            if (ls) begin
                                run++;
                                if (run == LF) begin
                                    phase = P_SEQ;
                                    t     = 0;
                                end
                            end else begin
                                run = 0;
                            end
                        end
                        P_SEQ: begin
                            if (!ls || sw) begin
                                if (!ls) el = 1'b1;
                                phase = P_HOLD;
                                t     = 0;
                                er    = '0;
                                ed    = 1'b0;
                            end else begin
                                t++;
                                for (int k = 0; k < NC; k++) er[k] = (t >= cum[k]);
                                ed = (t >= cum[NC-1]);
                            end
                        end
                        default: begin
                            t++;
                            if (t == MA) begin
                                phase = P_WAIT;
                                run   = 0;
                            end
                        end
                    endcase
                end
            end
        end

        initial begin : cmp
            forever begin
                @(negedge clk);
                check($sformatf("cfg%0d rst_n_o", g), 64'(rv), 64'(er));
                check($sformatf("cfg%0d rst_done_o", g), 64'(done), 64'(ed));
                check($sformatf("cfg%0d lock_lost_o", g), 64'(lost), 64'(el));
            end
        end
    end

    task automatic wait_for(input logic [3:0] mask, input int budget, input string name, output int n);
        n = 0;
        while (n < budget) begin
            tick();
            n++;
            if (g_cfg[0].rv === mask) return;
        end
        vectors++;
        miscompares++;
        $display("FAIL %s: rst_n_o never reached %b within %0d cycles, last %b", name, mask, budget, g_cfg[0].rv);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: time limit reached, vectors=%0d", vectors);
        $fatal(1, "simulation time limit");
    end

    initial begin : stim
        int n;
        int clean;

        pll   = 1'b1;
        sw    = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        check("reset rst_n_o", 64'(g_cfg[0].rv), 64'h0);
        check("reset rst_done_o", 64'(g_cfg[0].done), 64'h0);
        check("reset lock_lost_o", 64'(g_cfg[0].lost), 64'h0);

        // Clean power-up with lock already stable.
        rst_n = 1'b1;
        wait_for(4'b0001, 60, "clean ch0", n);
        clean = n;
        check("clean ch0 latency within 22..24", 64'(n >= 22 && n <= 24), 64'h1);
        wait_for(4'b0011, 20, "clean ch1", n);
        check("clean ch1 spacing", 64'(n), 64'd5);
        wait_for(4'b0111, 20, "clean ch2", n);
        check("clean ch2 spacing", 64'(n), 64'd5);
        wait_for(4'b1111, 20, "clean ch3", n);
        check("clean ch3 spacing", 64'(n), 64'd5);
        check("clean rst_done_o with 1111", 64'(g_cfg[0].done), 64'h1);
        check("clean lock_lost_o", 64'(g_cfg[0].lost), 64'h0);

        // One-cycle lock glitch arriving when the filter count is 10.
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        repeat (10) tick();
        pll = 1'b0;
        tick();
        pll = 1'b1;
        wait_for(4'b0001, 80, "glitch ch0", n);
        check("glitch extra delay", 64'(11 + n - clean), 64'd11);
        wait_for(4'b1111, 60, "glitch full", n);

        // Lock loss while running.
        repeat (3) tick();
        pll = 1'b0;
        wait_for(4'b0000, 3, "lock loss clears outputs", n);
        check("lock loss rst_done_o", 64'(g_cfg[0].done), 64'h0);
        check("lock loss lock_lost_o", 64'(g_cfg[0].lost), 64'h1);
        pll = 1'b1;
        wait_for(4'b1111, 300, "resequence after loss", n);
        check("sticky lock_lost_o", 64'(g_cfg[0].lost), 64'h1);
        check("resequence rst_done_o", 64'(g_cfg[0].done), 64'h1);

        // Software request in RUN, then async reset in the middle of RELEASE.
        sw = 1'b1;
        tick();
        sw = 1'b0;
        check("sw in RUN clears outputs", 64'(g_cfg[0].rv), 64'h0);
        wait_for(4'b0011, 200, "resequence after sw", n);
        #1;
        rst_n = 1'b0;
        #1;
        check("async rst rst_n_o", 64'(g_cfg[0].rv), 64'h0);
        check("async rst rst_done_o", 64'(g_cfg[0].done), 64'h0);
        check("async rst lock_lost_o", 64'(g_cfg[0].lost), 64'h0);
        tick();
        tick();
        rst_n = 1'b1;
        wait_for(4'b0001, 60, "after async rst ch0", n);
        check("after async rst latency", 64'(n), 64'(clean));

        // Software request landing on the cycle channel 2 would be released.
        wait_for(4'b0011, 20, "collision ch1", n);
        repeat (4) tick();
        sw = 1'b1;
        tick();
        sw = 1'b0;
        check("no release on hold entry", 64'(g_cfg[0].rv), 64'h0);
        wait_for(4'b1111, 200, "resequence after collision", n);
        check("sw keeps lock_lost_o low", 64'(g_cfg[0].lost), 64'h0);

        // Randomised lock drops, software requests and occasional resets.
        repeat (4000) begin
            tick();
            if (pll) pll = ($urandom_range(0, 199) != 0);
            else     pll = ($urandom_range(0, 3) == 0);
            sw = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 799) == 0) begin
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end
        end
        sw = 1'b0;
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
